// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encodings (also used by the
// transmitter), default line timing and a clocks-per-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_CLK_FREQ  = 10000;
  localparam int UART_BAUD_RATE = 1000;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx line plus a 1->0 edge detect.
// Flops reset high so an idle line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = rx;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s = s2_q;
  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/[parity]/stop framing with a one-word holding
// register. Define UART_RX_PARITY_EN to expect and check an even parity bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = UART_CLK_FREQ,
  parameter int BAUD_RATE = UART_BAUD_RATE,
  parameter int DATA_SIZE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       out_ready,
  output logic [9:0] data_out,
  output logic       out_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [3:0]    LAST = 4'(DATA_SIZE - 1);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (rx_fall)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          load;
  logic          stop_bad;

  logic [9:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic          pbad_q, pbad_d;
  logic          perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    load     = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            bit_d   = '0;
            shift_d = '0;
`ifdef UART_RX_PARITY_EN
            pbad_d  = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 1'b1;
          if (bit_q == LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          pbad_d  = rx_s ^ (^shift_q);
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
          load     = 1'b1;
          stop_bad = ~rx_s;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A finished frame only lands if the slot is empty or drained this edge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (load) begin
      if (valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = stop_bad;
`ifdef UART_RX_PARITY_EN
        perr_d  = pbad_q;
`endif
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
